dmem_ctrl: RTL and testbench

- Sequencing controller in front of the word-addressed, single-port data memory. The memory has a combinational read and a synchronous whole-word write.
- Shares that memory between two requesters: port 0 is the core load/store unit; port 1 is the debug/program-loader port.
- Converts RISC-V byte/halfword/word loads and stores into word accesses:
  - sub-word loads: lane extraction plus sign/zero extension;
  - sub-word stores: read-modify-write (RMW) sequence.
- Flags misaligned accesses and illegal sizes.

---
 rtl/dmem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmem_ctrl
// Brief   : Two-port sequencer for a single-port word memory; handles byte/half
//           loads (lane extract + extend) and sub-word stores (read-modify-write).
// Rev     : 1.0  initial release
// ============================================================================
module dmem_ctrl #(
  parameter int N      = 32,
  parameter int A      = 32,
  parameter int MEM_AW = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_we,
  input  logic [1:0]   req0_size,
  input  logic         req0_unsigned,
  input  logic [A-1:0] req0_addr,
  input  logic [N-1:0] req0_wdata,
  output logic         rsp0_valid,
  output logic [N-1:0] rsp0_rdata,
  output logic         rsp0_err,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_we,
  input  logic [1:0]   req1_size,
  input  logic         req1_unsigned,
  input  logic [A-1:0] req1_addr,
  input  logic [N-1:0] req1_wdata,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp1_rdata,
  output logic         rsp1_err,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_grant;
  logic                r_port;
  logic                r_we;
  logic                r_uns;
  logic                r_err;
  logic [1:0]          r_size;
  logic [MEM_AW+1:0]   r_addr;
  logic [N-1:0]        r_wdata;
  logic [N-1:0]        r_word;
  logic [N-1:0]        r_rdata;

  logic                w_acc0;
  logic                w_acc1;
  logic                w_accept;
  logic                w_sel_we;
  logic                w_sel_uns;
  logic [1:0]          w_sel_size;
  logic [MEM_AW+1:0]   w_sel_addr;
  logic [N-1:0]        w_sel_wdata;
  logic                w_word_st;
  logic                w_subword_st;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [N-1:0]        w_load;
  logic [N-1:0]        w_merged;
  logic                w_unused;

  function automatic logic f_bad(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) || (size == c_SZ_HALF && lo[0]) ||
           (size == c_SZ_WORD && lo != 2'b00);
  endfunction

  // Port 0 wins a tie unless it was the last one granted.
  assign req0_ready = (r_state == S_IDLE) && req0_valid && (!req1_valid || r_last_grant);
  assign req1_ready = (r_state == S_IDLE) && req1_valid && (!req0_valid || !r_last_grant);
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;
  assign w_accept   = w_acc0 || w_acc1;

  assign w_sel_we    = w_acc1 ? req1_we                  : req0_we;
  assign w_sel_uns   = w_acc1 ? req1_unsigned            : req0_unsigned;
  assign w_sel_size  = w_acc1 ? req1_size                : req0_size;
  assign w_sel_addr  = w_acc1 ? req1_addr[MEM_AW+1:0]    : req0_addr[MEM_AW+1:0];
  assign w_sel_wdata = w_acc1 ? req1_wdata               : req0_wdata;
  assign w_unused    = &{1'b0, req0_addr[A-1:MEM_AW+2], req1_addr[A-1:MEM_AW+2]};

  assign w_word_st    = r_we && !r_err && (r_size == c_SZ_WORD);
  assign w_subword_st = r_we && !r_err && (r_size != c_SZ_WORD);

  assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = mem_rdata;
    case (r_size)
      c_SZ_BYTE: w_load = {{(N-8){~r_uns & w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load = {{(N-16){~r_uns & w_half[15]}}, w_half};
      default:   w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = r_word;
    if (r_size == c_SZ_BYTE) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_err        <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_word       <= '0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last_grant <= w_acc1;
        r_port       <= w_acc1;
        r_we         <= w_sel_we;
        r_uns        <= w_sel_uns;
        r_size       <= w_sel_size;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_err        <= f_bad(w_sel_size, w_sel_addr[1:0]);
      end
      if (r_state == S_ACCESS) begin
        r_word  <= mem_rdata;
        r_rdata <= (r_we || r_err) ? '0 : w_load;
      end
    end
  end

  // mem_we is decoded from state so an asynchronous reset removes it at once.
  always_comb begin
    w_next    = r_state;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_next = w_subword_st ? S_MERGE : S_RESP;
        if (w_word_st) begin
          mem_we    = 1'b1;
          mem_wdata = r_wdata;
        end
      end
      S_MERGE: begin
        w_next    = S_RESP;
        mem_we    = 1'b1;
        mem_wdata = w_merged;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_addr = (r_state == S_ACCESS || r_state == S_MERGE) ?
                    {{(A-MEM_AW){1'b0}}, r_addr[MEM_AW+1:2]} : '0;

  assign rsp0_valid = (r_state == S_RESP) && !r_port;
  assign rsp1_valid = (r_state == S_RESP) &&  r_port;
  assign rsp0_rdata = rsp0_valid ? r_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? r_rdata : '0;
  assign rsp0_err   = rsp0_valid && r_err;
  assign rsp1_err   = rsp1_valid && r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_ctrl
// Brief   : Directed and random requests on both ports versus a byte-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_unsigned;
  logic [1:0]  req0_size;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_unsigned;
  logic [1:0]  req1_size;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [4096];
  int          ref_b [16384];
  logic        bd_we = 1'b0;
  logic [11:0] bd_idx;
  logic [31:0] bd_data;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_size(req0_size), .req0_unsigned(req0_unsigned), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_size(req1_size), .req1_unsigned(req1_unsigned), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input bit [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input bit [1:0] sz, input bit uns, input logic [31:0] a);
    int     b = int'(a[13:0]);
    longint v;
    if (sz == 2'b00) begin
      v = ref_b[b];
      if (!uns && v >= 128) v -= 256;
    end else if (sz == 2'b01) begin
      v = ref_b[b] + 256 * ref_b[b+1];
      if (!uns && v >= 32768) v -= 65536;
    end else begin
      v = longint'(ref_b[b]) + 256 * longint'(ref_b[b+1]) +
          65536 * longint'(ref_b[b+2]) + 16777216 * longint'(ref_b[b+3]);
    end
    return 32'(v);
  endfunction

  task automatic model_store(input bit [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b = int'(a[13:0]);
    for (int i = 0; i < (1 << sz); i++) ref_b[b+i] = int'((d >> (8*i)) & 32'hFF);
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return 32'(ref_b[4*w]) | (32'(ref_b[4*w+1]) << 8) |
           (32'(ref_b[4*w+2]) << 16) | (32'(ref_b[4*w+3]) << 24);
  endfunction

  task automatic poke(input int w, input logic [31:0] v);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 12'(w); bd_data = v;
    @(negedge clk);
    bd_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4*w+i] = int'((v >> (8*i)) & 32'hFF);
  endtask

  task automatic set_req(input int p, input bit v, input bit we, input bit [1:0] sz,
                         input bit uns, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_size = sz; req0_unsigned = uns;
      req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_size = sz; req1_unsigned = uns;
      req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic do_req(input string tag, input int p, input bit we, input bit [1:0] sz,
                        input bit uns, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] o_rd);
    bit e_err; logic [31:0] e_rd, e_word; int e_lat, e_wek, w;
    int lat, nwe, wek, other; bit rdy, er; logic [31:0] rd, wdat, wadr;
    w      = int'(a[13:2]);
    e_err  = model_err(sz, a);
    e_rd   = (we || e_err) ? 32'h0 : model_load(sz, uns, a);
    if (we && !e_err) model_store(sz, a, d);
    e_word = ref_word(w);
    e_lat  = (we && !e_err && sz != 2'b10) ? 3 : 2;
    e_wek  = (!we || e_err) ? 0 : ((sz == 2'b10) ? 1 : 2);
    o_rd   = 32'h0;
    @(negedge clk);
    set_req(p, 1'b1, we, sz, uns, a, d);
    rdy = 1'b0;
    for (int c = 0; c < 20 && !rdy; c++) begin
      #1 rdy = (p == 0) ? req0_ready : req1_ready;
      if (!rdy) @(negedge clk);
    end
    check({tag, " accept"}, 32'(rdy), 32'd1);
    if (!rdy) begin
      set_req(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      return;
    end
    @(posedge clk);
    #1 set_req(p, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    lat = 0; nwe = 0; wek = 0; other = 0; er = 1'b0;
    rd = 32'h0; wdat = 32'h0; wadr = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (mem_we) begin nwe++; wek = k; wdat = mem_wdata; wadr = mem_addr; end
      if ((p == 0) ? rsp1_valid : rsp0_valid) other++;
      if (((p == 0) ? rsp0_valid : rsp1_valid) && lat == 0) begin
        lat = k;
        rd  = (p == 0) ? rsp0_rdata : rsp1_rdata;
        er  = (p == 0) ? rsp0_err   : rsp1_err;
      end
    end
    o_rd = rd;
    check({tag, " latency"}, 32'(lat), 32'(e_lat));
    check({tag, " rdata"}, rd, e_rd);
    check({tag, " err"}, 32'(er), 32'(e_err));
    check({tag, " we count"}, 32'(nwe), (e_wek != 0) ? 32'd1 : 32'd0);
    check({tag, " other rsp"}, 32'(other), 32'd0);
    if (e_wek != 0) begin
      check({tag, " we phase"}, 32'(wek), 32'(e_wek));
      check({tag, " we addr"}, wadr, 32'(w));
      check({tag, " we data"}, wdat, e_word);
    end
    check({tag, " mem word"}, mem[w], e_word);
  endtask

  initial begin
    logic [31:0] rd;
    int          grants[$];
    int          pend[$];
    int          both, nrsp, wrong, ep, gcnt;
    logic [31:0] e0, e1;
    bit          rdy;

    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset mem_we", mem_we, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset rsp0_valid", rsp0_valid, 32'h0);
    check("reset rsp1_valid", rsp1_valid, 32'h0);
    check("reset rsp0_rdata", rsp0_rdata, 32'h0);
    check("reset rsp1_err", rsp1_err, 32'h0);
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    @(negedge clk) rst = 1'b0;

    // Contention: both ports hold word loads; grants must alternate from port 0.
    e0 = model_load(2'b10, 1'b0, 32'h20);
    e1 = model_load(2'b10, 1'b0, 32'h24);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    both = 0; nrsp = 0; wrong = 0;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) both++;
      if (req0_ready) begin grants.push_back(0); pend.push_back(0); end
      else if (req1_ready) begin grants.push_back(1); pend.push_back(1); end
      if (rsp0_valid || rsp1_valid) begin
        ep = (pend.size() > 0) ? pend.pop_front() : -1;
        if (rsp0_valid && rsp1_valid) wrong++;
        if (ep == 0) begin
          check("contend rsp port0", {rsp1_valid, rsp0_valid}, 32'h1);
          check("contend rdata0", rsp0_rdata, e0);
        end else begin
          check("contend rsp port1", {rsp1_valid, rsp0_valid}, 32'h2);
          check("contend rdata1", rsp1_rdata, e1);
        end
        nrsp++;
      end
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("contend responses", 32'(nrsp), 32'd4);
    check("contend both ready", 32'(both), 32'd0);
    check("contend both rsp", 32'(wrong), 32'd0);
    gcnt = grants.size();
    check("contend grant count", 32'(gcnt), 32'd4);
    for (int i = 0; i < 4 && i < gcnt; i++)
      check("contend grant order", 32'(grants[i]), 32'(i % 2));

    // Directed operations with spec-given results.
    do_req("SW 0x10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
    do_req("LW 0x10", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
    check("LW 0x10 value", rd, 32'hDEADBEEF);
    poke(4, 32'h11223344);
    do_req("SB 0x12", 0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, rd);
    check("SB 0x12 word", mem[4], 32'h11AA3344);
    poke(8, 32'h80FF7F01);
    do_req("LB 0x21", 0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd);
    check("LB 0x21 value", rd, 32'h0000007F);
    do_req("LB 0x22", 1, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, rd);
    check("LB 0x22 value", rd, 32'hFFFFFFFF);
    do_req("LBU 0x23", 0, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, rd);
    check("LBU 0x23 value", rd, 32'h00000080);
    do_req("LH 0x22", 1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd);
    check("LH 0x22 value", rd, 32'hFFFF80FF);
    do_req("LW 0x6 err", 1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rd);
    do_req("SH 0x3 err", 0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h12345678, rd);
    do_req("size11 err", 1, 1'b0, 2'b11, 1'b0, 32'h8, 32'h0, rd);

    // Random traffic, including upper address bits that must wrap.
    for (int i = 0; i < 150; i++)
      do_req("random", int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom),
             1'($urandom), $urandom & 32'hF000003F, $urandom, rd);

    // Reset during the merge cycle of a byte store.
    poke(4, 32'h11223344);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    rdy = 1'b0;
    for (int c = 0; c < 20 && !rdy; c++) begin
      #1 rdy = req0_ready;
      if (!rdy) @(negedge clk);
    end
    check("rmw rst accept", 32'(rdy), 32'd1);
    @(posedge clk);
    #1 set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rmw rst access we", mem_we, 32'h0);
    @(negedge clk);
    check("rmw rst merge we", mem_we, 32'h1);
    #1 rst = 1'b1;
    #1 check("rmw rst we drop", mem_we, 32'h0);
    wrong = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) wrong++;
    end
    check("rmw rst no rsp", 32'(wrong), 32'd0);
    check("rmw rst mem kept", mem[4], 32'h11223344);
    rst = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    #1;
    check("post rst ready0", req0_ready, 32'h1);
    check("post rst ready1", req1_ready, 32'h0);
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
